axis_measure_poller: RTL and testbench
======================================

Name: axis_measure_poller

Overview:
- AXI4-Lite master (initiator) that drives the control register of an AXI-Stream measurement block and periodically reads back its counters.
- Sits between fabric control logic and the measurer's s_axi_control slave port.
- Converts simple start/stop/clear commands into register writes.
- Publishes coherent-per-poll 64-bit snapshots of the assertion and cycle counters.

Parameters:
- POLL_INTERVAL, 1024, ap_clk cycles between poll triggers while poll_en=1; legal range 4..2^32-1.
- CONTROL_ADDR, 16'd16, byte address of the control register.
- ASSERTIONS_ADDR, 16'd20, byte address of assertions[31:0]; [63:32] is at +4.
- CYCLES_ADDR, 16'd28, byte address of cycles_total[31:0]; [63:32] is at +4.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=stop (wdata 0), 1=start (wdata 1), 2=clear (wdata 2), 3=reserved (ignored, accepted, no write)
- poll_en  in  1  enables the periodic poll timer
- m_axi_awvalid / m_axi_awready  out / in  1 / 1  write address handshake
- m_axi_awaddr  out  16  write address
- m_axi_wvalid / m_axi_wready  out / in  1 / 1  write data handshake
- m_axi_wdata  out  32  write data
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_bvalid / m_axi_bready  in / out  1 / 1  write response handshake
- m_axi_bresp  in  2  write response
- m_axi_arvalid / m_axi_arready  out / in  1 / 1  read address handshake
- m_axi_araddr  out  16  read address
- m_axi_rvalid / m_axi_rready  in / out  1 / 1  read data handshake
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- snap_valid  out  1  one-cycle pulse: snapshot outputs updated
- snap_assertions  out  64  last polled assertion count
- snap_cycles  out  64  last polled cycle count
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all m_axi valids/readies 0; awaddr/araddr/wdata 0; snap_* 0; snap_valid 0; timer 0; poll_pending 0.
- cmd_ready = (state==IDLE). Commands are only accepted in IDLE.
- Poll timer:
  - While poll_en=1, counts 0..POLL_INTERVAL-1; at terminal count sets poll_pending and wraps to 0.
  - poll_en=0 clears the timer; poll_pending is kept.
  - Triggers that arrive while poll_pending is already 1 coalesce into a single poll.
- IDLE priority: a valid command beats a pending poll (command accepted that cycle). Otherwise, if poll_pending, go to RD_ADDR with index=0 and clear poll_pending.
- WR_ADDR (command accepted):
  - Next cycle: awvalid=wvalid=1, awaddr=CONTROL_ADDR, wdata=zero-extended cmd_op.
  - Each valid drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - Once both have completed, go to WR_RESP.
- WR_RESP: bready=1; on bvalid go to IDLE.
- RD_ADDR:
  - arvalid=1; araddr by index: 0=ASSERTIONS_ADDR, 1=+4, 2=CYCLES_ADDR, 3=+4.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1; on rvalid, capture rdata into a shadow word by index.
  - If index<3: index++ and return to RD_ADDR. If index==3: go to DONE.
- DONE: copy shadow into snap_* and pulse snap_valid for exactly 1 cycle, then go to IDLE.
- snap_* change only in DONE, so partial polls are never visible.
- Exactly one outstanding transaction at any time; valids are never withdrawn before their handshake.
- Minimum poll latency, trigger to snap_valid: 1 (IDLE) + 4×2 (AR+R, zero-wait slave) + 1 (DONE) = 10 cycles.
- Reset mid-transaction abandons it immediately. Integrator must reset the slave together with this block.

Optional Feature:
- Macro: AXIS_MEASURE_POLLER_RESP_CHECK_EN.
- Defined:
  - Adds output resp_err (1 bit, sticky, reset 0).
  - Adds input resp_err_clr (1 bit); resp_err_clr clears resp_err, but a simultaneous new error wins.
  - Any bresp or rresp != 2'b00 sets resp_err.
  - A poll with any bad rresp completes all 4 reads but skips the snapshot update and the snap_valid pulse.
- Undefined: bresp/rresp are ignored; resp_err and resp_err_clr ports do not exist.

Test Plan:
- Reset, then cmd_op=1 with zero-wait slave -> one AW/W handshake: awaddr=16, wdata=1; bready until bvalid; cmd_ready high again 3 cycles after acceptance.
- Slave delays awready 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles; exactly one B accepted.
- POLL_INTERVAL=16, poll_en=1, slave returns 0x5,0x1,0xA,0x0 -> araddr sequence 20,24,28,32; snap_assertions=0x1_00000005, snap_cycles=0xA; snap_valid one cycle, 10 cycles after trigger.
- cmd_valid and poll trigger in the same IDLE cycle -> write completes first, then the poll runs; a second trigger during the poll coalesces into exactly one follow-up poll.
- ap_rst_n asserted while in RD_DATA with index=2 -> all valids 0 immediately; snap_* return to 0; no snap_valid.
- (RESP_CHECK_EN) rresp=2'b10 on word 1 -> resp_err=1, no snap_valid, snap_* keep prior values; resp_err_clr clears the flag.

Source files
------------

// File: rtl/axis_measure_poller.sv
// AXI4-Lite master: turns start/stop/clear commands into control-register writes and periodically
// polls the measurer's 64-bit counters. Define AXIS_MEASURE_POLLER_RESP_CHECK_EN for resp_err reporting.
module axis_measure_poller #(
    parameter int unsigned POLL_INTERVAL   = 1024,
    parameter logic [15:0] CONTROL_ADDR    = 16'd16,
    parameter logic [15:0] ASSERTIONS_ADDR = 16'd20,
    parameter logic [15:0] CYCLES_ADDR     = 16'd28
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        poll_en,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [15:0] m_axi_awaddr,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [15:0] m_axi_araddr,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    output logic        snap_valid,
    output logic [63:0] snap_assertions,
    output logic [63:0] snap_cycles,
`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
    input  logic        resp_err_clr,
    output logic        resp_err,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    localparam logic [31:0] TIMER_LAST = 32'(POLL_INTERVAL - 1);

    state_t      state_reg, state_next;
    logic [1:0]  index_reg, index_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic [15:0] awaddr_reg;
    logic [15:0] araddr_reg, araddr_next;
    logic [31:0] wdata_reg;
    logic [31:0] timer_reg;
    logic        poll_pending_reg;
    logic        poll_trigger;
    logic        cmd_write, take_poll, rd_beat, last_beat, snap_ok;
    logic        snap_valid_reg;
    logic [63:0] snap_assertions_reg, snap_cycles_reg;

    // Read address for each of the four counter words, low word first.
    function automatic logic [15:0] rd_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    rd_addr = ASSERTIONS_ADDR;
            2'd1:    rd_addr = ASSERTIONS_ADDR + 16'd4;
            2'd2:    rd_addr = CYCLES_ADDR;
            default: rd_addr = CYCLES_ADDR + 16'd4;
        endcase
    endfunction

    assign cmd_ready     = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign m_axi_awvalid = (state_reg == WR_ADDR) && !aw_done_reg;
    assign m_axi_wvalid  = (state_reg == WR_ADDR) && !w_done_reg;
    assign m_axi_bready  = (state_reg == WR_RESP);
    assign m_axi_arvalid = (state_reg == RD_ADDR);
    assign m_axi_rready  = (state_reg == RD_DATA);
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_araddr  = araddr_reg;
    assign snap_valid      = snap_valid_reg;
    assign snap_assertions = snap_assertions_reg;
    assign snap_cycles     = snap_cycles_reg;

    assign poll_trigger = poll_en && (timer_reg == TIMER_LAST);
    assign last_beat    = rd_beat && (index_reg == 2'd3);

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        araddr_next  = araddr_reg;
        cmd_write    = 1'b0;
        take_poll    = 1'b0;
        rd_beat      = 1'b0;
        case (state_reg)
            IDLE: begin
                // Commands win over a pending poll; reserved op is accepted without a write.
                if (cmd_valid) begin
                    if (cmd_op != 2'd3) begin
                        cmd_write    = 1'b1;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                        state_next   = WR_ADDR;
                    end
                end else if (poll_pending_reg) begin
                    take_poll   = 1'b1;
                    index_next  = 2'd0;
                    araddr_next = rd_addr(2'd0);
                    state_next  = RD_ADDR;
                end
            end
            WR_ADDR: begin
                aw_done_next = aw_done_reg | (m_axi_awvalid & m_axi_awready);
                w_done_next  = w_done_reg | (m_axi_wvalid & m_axi_wready);
                if (aw_done_next && w_done_next)
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid)
                    state_next = IDLE;
            end
            RD_ADDR: begin
                if (m_axi_arready)
                    state_next = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rd_beat = 1'b1;
                    if (index_reg == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        index_next  = index_reg + 2'd1;
                        araddr_next = rd_addr(index_reg + 2'd1);
                        state_next  = RD_ADDR;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow words 0..2; word 3 is taken straight from the bus on the final beat.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
            logic [31:0] word_reg;
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n)
                    word_reg <= '0;
                else if (rd_beat && (index_reg == 2'(gi)))
                    word_reg <= m_axi_rdata;
            end
        end
    endgenerate

`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
    logic bad_poll_reg;
    logic resp_err_reg;
    logic new_err;

    assign new_err  = ((state_reg == WR_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) ||
                      (rd_beat && (m_axi_rresp != 2'b00));
    assign snap_ok  = !(bad_poll_reg || (m_axi_rresp != 2'b00));
    assign resp_err = resp_err_reg;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bad_poll_reg <= 1'b0;
            resp_err_reg <= 1'b0;
        end else begin
            if (take_poll)
                bad_poll_reg <= 1'b0;
            else if (rd_beat && (m_axi_rresp != 2'b00))
                bad_poll_reg <= 1'b1;
            resp_err_reg <= new_err | (resp_err_reg & ~resp_err_clr);
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
    assign snap_ok     = 1'b1;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg           <= IDLE;
            index_reg           <= 2'd0;
            aw_done_reg         <= 1'b0;
            w_done_reg          <= 1'b0;
            awaddr_reg          <= '0;
            araddr_reg          <= '0;
            wdata_reg           <= '0;
            timer_reg           <= '0;
            poll_pending_reg    <= 1'b0;
            snap_valid_reg      <= 1'b0;
            snap_assertions_reg <= '0;
            snap_cycles_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            araddr_reg  <= araddr_next;
            if (cmd_write) begin
                awaddr_reg <= CONTROL_ADDR;
                wdata_reg  <= {30'd0, cmd_op};
            end
            if (!poll_en || poll_trigger)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 32'd1;
            // A trigger while a poll is already pending folds into that poll.
            poll_pending_reg <= (poll_pending_reg & ~take_poll) | poll_trigger;
            snap_valid_reg   <= last_beat & snap_ok;
            if (last_beat && snap_ok) begin
                snap_assertions_reg <= {g_shadow[1].word_reg, g_shadow[0].word_reg};
                snap_cycles_reg     <= {m_axi_rdata, g_shadow[2].word_reg};
            end
        end
    end

endmodule

// File: tb/tb_axis_measure_poller.sv
// Directed bench for axis_measure_poller with a behavioural AXI4-Lite slave (configurable AW and R wait states).
`timescale 1ns/1ps
module tb_axis_measure_poller;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        poll_en;
    logic        m_axi_awvalid, m_axi_awready;
    logic [15:0] m_axi_awaddr;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [15:0] m_axi_araddr;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        snap_valid;
    logic [63:0] snap_assertions, snap_cycles;
    logic        busy;
`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
    logic        resp_err_clr;
    logic        resp_err;
`endif

    always #5 ap_clk = ~ap_clk;

    axis_measure_poller #(.POLL_INTERVAL(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .poll_en(poll_en),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp),
        .snap_valid(snap_valid), .snap_assertions(snap_assertions), .snap_cycles(snap_cycles),
`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
        .resp_err_clr(resp_err_clr), .resp_err(resp_err),
`endif
        .busy(busy)
    );

    // ---------------- slave model ----------------
    int          aw_wait = 0;
    int          r_wait  = 0;
    int          aw_cnt;
    int          r_cnt;
    logic        r_pend;
    logic        aw_got, w_got;
    logic        aw_fin, w_fin;
    logic [31:0] mem [0:3];
    logic [15:0] bad_addr = 16'hFFFF;
    logic [1:0]  bresp_val = 2'b00;
    logic [15:0] rd_off;

    assign m_axi_awready = (aw_cnt >= aw_wait);
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = 1'b1;
    assign m_axi_bresp   = bresp_val;
    assign aw_fin = aw_got | (m_axi_awvalid & m_axi_awready);
    assign w_fin  = w_got  | (m_axi_wvalid & m_axi_wready);
    assign rd_off = (m_axi_araddr - 16'd20) >> 2;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            aw_cnt       <= 0;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            m_axi_bvalid <= 1'b0;
            m_axi_rvalid <= 1'b0;
            m_axi_rdata  <= '0;
            m_axi_rresp  <= 2'b00;
            r_pend       <= 1'b0;
            r_cnt        <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) aw_cnt <= 0;
            else if (m_axi_awvalid)             aw_cnt <= aw_cnt + 1;
            if (aw_fin && w_fin && !m_axi_bvalid) begin
                m_axi_bvalid <= 1'b1;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end else begin
                aw_got <= aw_fin;
                w_got  <= w_fin;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rdata <= mem[rd_off[1:0]];
                m_axi_rresp <= (m_axi_araddr == bad_addr) ? 2'b10 : 2'b00;
                if (r_wait == 0) m_axi_rvalid <= 1'b1;
                else begin
                    r_pend <= 1'b1;
                    r_cnt  <= r_wait - 1;
                end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    m_axi_rvalid <= 1'b1;
                    r_pend       <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0, awv_cycles = 0, wv_cycles = 0, b_count = 0, ar_count = 0, snap_count = 0;
    int          last_b_cyc = 0;
    int          ar_cyc_log [0:31];
    logic [15:0] ar_log [0:31];
    logic [15:0] last_awaddr = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (m_axi_awvalid) awv_cycles <= awv_cycles + 1;
        if (m_axi_wvalid)  wv_cycles  <= wv_cycles + 1;
        if (m_axi_awvalid && m_axi_awready) last_awaddr <= m_axi_awaddr;
        if (m_axi_wvalid && m_axi_wready)   last_wdata  <= m_axi_wdata;
        if (m_axi_bvalid && m_axi_bready) begin
            b_count    <= b_count + 1;
            last_b_cyc <= cyc;
            $display("[%0t] WRITE addr=%0d data=0x%0h", $time, last_awaddr, last_wdata);
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_log[ar_count % 32]     <= m_axi_araddr;
            ar_cyc_log[ar_count % 32] <= cyc;
            ar_count                  <= ar_count + 1;
        end
        if (m_axi_rvalid && m_axi_rready)
            $display("[%0t] READ  data=0x%0h resp=%0d", $time, m_axi_rdata, m_axi_rresp);
        if (snap_valid) begin
            snap_count <= snap_count + 1;
            $display("[%0t] SNAP  assertions=0x%0h cycles=0x%0h", $time, snap_assertions, snap_cycles);
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one command; n = posedges from the accept edge until cmd_ready is seen again.
    task automatic do_cmd(input logic [1:0] op, output int n);
        int k;
        @(negedge ap_clk);
        cmd_op    = op;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        @(posedge ap_clk);
        #1;
        cmd_valid = 1'b0;
        n = 1;
        while (!cmd_ready && n < 50) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
    endtask

    // Wait for snap_valid; n = posedges waited (capped at limit).
    task automatic wait_snap(input int limit, output int n);
        n = 0;
        do begin
            @(posedge ap_clk);
            #1;
            n++;
        end while (!snap_valid && n < limit);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ar_base, b_base, awv_base, wv_base, snap_base;
        mem[0] = 32'h5; mem[1] = 32'h1; mem[2] = 32'hA; mem[3] = 32'h0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        poll_en   = 1'b0;
        ap_rst_n  = 1'b0;
`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
        resp_err_clr = 1'b0;
`endif
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_addrs", {m_axi_awaddr, m_axi_araddr}, 0);
        check("rst_wdata", m_axi_wdata, 0);
        check("rst_wstrb", m_axi_wstrb, 4'hF);
        check("rst_snap", {snap_valid, busy}, 0);
        check("rst_snap_assertions", snap_assertions, 0);
        check("rst_snap_cycles", snap_cycles, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk);

        // start command, zero-wait slave
        b_base = b_count; awv_base = awv_cycles; wv_base = wv_cycles;
        do_cmd(2'd1, n);
        check("t1_ready_latency", n, 3);
        check("t1_awaddr", last_awaddr, 16);
        check("t1_wdata", last_wdata, 1);
        check("t1_b_count", b_count - b_base, 1);
        check("t1_aw_cycles", awv_cycles - awv_base, 1);

        // stop command with AW held off two cycles
        aw_wait = 2;
        b_base = b_count; awv_base = awv_cycles; wv_base = wv_cycles;
        do_cmd(2'd0, n);
        aw_wait = 0;
        check("t2_aw_cycles", awv_cycles - awv_base, 3);
        check("t2_w_cycles", wv_cycles - wv_base, 1);
        check("t2_b_count", b_count - b_base, 1);
        check("t2_wdata", last_wdata, 0);
        check("t2_ready_latency", n, 5);

        // reserved op: accepted, no write
        b_base = b_count; awv_base = awv_cycles;
        do_cmd(2'd3, n);
        repeat (3) @(posedge ap_clk);
        #1;
        check("t2r_no_write", (b_count - b_base) + (awv_cycles - awv_base), 0);

        // periodic poll
        ar_base = ar_count;
        @(negedge ap_clk);
        poll_en = 1'b1;
        wait_snap(200, n);
        check("t3_latency", n, 25);
        check("t3_snap_assertions", snap_assertions, 64'h1_0000_0005);
        check("t3_snap_cycles", snap_cycles, 64'hA);
        check("t3_ar_count", ar_count - ar_base, 4);
        check("t3_araddr0", ar_log[(ar_base + 0) % 32], 20);
        check("t3_araddr1", ar_log[(ar_base + 1) % 32], 24);
        check("t3_araddr2", ar_log[(ar_base + 2) % 32], 28);
        check("t3_araddr3", ar_log[(ar_base + 3) % 32], 32);
        @(posedge ap_clk);
        #1;
        check("t3_snap_pulse_width", snap_valid, 0);
        @(negedge ap_clk);
        poll_en = 1'b0;
        repeat (4) @(posedge ap_clk);

        // command and pending poll together; slow reads let triggers pile up
        ar_base = ar_count; b_base = b_count; snap_base = snap_count;
        @(negedge ap_clk);
        poll_en = 1'b1;
        repeat (16) @(posedge ap_clk);
        #1;
        check("t4_idle_at_trigger", busy, 0);
        cmd_op    = 2'd2;
        cmd_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        cmd_valid = 1'b0;
        r_wait    = 10;
        check("t4_cmd_wins", {m_axi_awvalid, m_axi_arvalid}, 2'b10);
        check("t4_wdata", m_axi_wdata, 2);
        wait_snap(400, n);
        poll_en = 1'b0;
        check("t4_first_snap", snap_valid, 1);
        check("t4_b_count", b_count - b_base, 1);
        check("t4_ar_count", ar_count - ar_base, 4);
        check("t4_write_before_read", ar_cyc_log[ar_base % 32] > last_b_cyc, 1);
        repeat (200) @(posedge ap_clk);
        #1;
        check("t4_coalesced_polls", snap_count - snap_base, 2);
        check("t4_total_reads", ar_count - ar_base, 8);
        r_wait = 0;

        // reset during RD_DATA of word 2
        r_wait = 5;
        snap_base = snap_count;
        @(negedge ap_clk);
        poll_en = 1'b1;
        n = 0;
        do begin
            @(posedge ap_clk);
            #1;
            n++;
        end while (!(m_axi_rready && m_axi_araddr == 16'd28) && n < 300);
        check("t5_reached_word2", m_axi_rready && (m_axi_araddr == 16'd28), 1);
        #2;
        ap_rst_n = 1'b0;
        poll_en  = 1'b0;
        #1;
        check("t5_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        check("t5_busy", busy, 0);
        check("t5_snap_assertions", snap_assertions, 0);
        check("t5_snap_cycles", snap_cycles, 0);
        r_wait = 0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (40) @(posedge ap_clk);
        #1;
        check("t5_no_snap", snap_count - snap_base, 0);
        check("t5_idle", busy, 0);

`ifdef AXIS_MEASURE_POLLER_RESP_CHECK_EN
        // good poll, then a poll with a bad rresp on word 1
        @(negedge ap_clk);
        poll_en = 1'b1;
        repeat (16) @(posedge ap_clk);
        #1;
        poll_en = 1'b0;
        repeat (20) @(posedge ap_clk);
        #1;
        check("t6_good_snap", snap_assertions, 64'h1_0000_0005);
        check("t6_no_err", resp_err, 0);
        mem[0] = 32'h7;
        bad_addr = 16'd24;
        ar_base = ar_count; snap_base = snap_count;
        @(negedge ap_clk);
        poll_en = 1'b1;
        repeat (16) @(posedge ap_clk);
        #1;
        poll_en = 1'b0;
        repeat (20) @(posedge ap_clk);
        #1;
        check("t6_all_reads", ar_count - ar_base, 4);
        check("t6_no_snap", snap_count - snap_base, 0);
        check("t6_snap_kept", snap_assertions, 64'h1_0000_0005);
        check("t6_resp_err", resp_err, 1);
        bad_addr = 16'hFFFF;
        @(negedge ap_clk);
        resp_err_clr = 1'b1;
        @(negedge ap_clk);
        resp_err_clr = 1'b0;
        check("t6_resp_err_clr", resp_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
